// File: rtl/spi_slave_agent.sv
// SPI slave endpoint: oversamples sclk/cs_n/mosi in the pclk domain, shifts words
// in on mosi and out on miso, and offers a valid/ready word interface to local logic.
module spi_slave_agent #(
  parameter int DATA_WIDTH = 8,
  parameter bit CPOL       = 1'b0,
  parameter bit CPHA       = 1'b0,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                  pclk,
  input  logic                  areset,
  input  logic                  sclk,
  input  logic                  cs_n,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  tx_underrun,
  output logic                  busy,
  output logic                  state_dbg
);

  localparam int CW = $clog2(DATA_WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t state_q, state_d;

  // [0],[1] synchronize, [2] is the previous value used for edge detection
  logic [2:0] sclk_sr, cs_sr, mosi_sr;

  logic [DATA_WIDTH-1:0] hold_data, tx_shift, rx_shift, tx_load, rx_next;
  logic                  hold_full, word_open, ur_pending;
  logic [CW-1:0]         cnt;

  logic sclk_rise, sclk_fall, lead_edge, trail_edge, sample_edge, shift_edge;
  logic cs_fall, cs_rise, enter, leave, in_word, word_start, ur_now, ur_defer;

  always_ff @(posedge pclk) begin
    if (areset) begin
      sclk_sr <= {3{CPOL}};
      cs_sr   <= 3'b111;
      mosi_sr <= 3'b000;
    end else begin
      sclk_sr <= {sclk_sr[1:0], sclk};
      cs_sr   <= {cs_sr[1:0], cs_n};
      mosi_sr <= {mosi_sr[1:0], mosi};
    end
  end

  assign sclk_rise   = sclk_sr[1] & ~sclk_sr[2];
  assign sclk_fall   = ~sclk_sr[1] & sclk_sr[2];
  assign cs_fall     = ~cs_sr[1] & cs_sr[2];
  assign cs_rise     = cs_sr[1] & ~cs_sr[2];
  assign lead_edge   = CPOL ? sclk_fall : sclk_rise;
  assign trail_edge  = CPOL ? sclk_rise : sclk_fall;
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge : trail_edge;

  always_ff @(posedge pclk) begin
    if (areset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    enter      = 1'b0;
    leave      = 1'b0;
    in_word    = 1'b0;
    word_start = 1'b0;
    ur_now     = 1'b0;
    ur_defer   = 1'b0;
    case (state_q)
      IDLE:    if (cs_fall) state_d = ACTIVE;
      ACTIVE:  if (cs_rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    enter   = (state_q == IDLE) && (state_d == ACTIVE);
    leave   = (state_q == ACTIVE) && (state_d == IDLE);
    in_word = (state_q == ACTIVE) && !leave;
    word_start = (enter && !CPHA) || (in_word && shift_edge && !word_open);
    // At a mid-frame CPHA=0 boundary the master may be ending the frame, so an
    // empty holding register is only reported once the word really samples a bit.
    ur_now   = word_start && !hold_full && (CPHA || enter);
    ur_defer = word_start && !hold_full && !CPHA && !enter;
  end

  assign tx_load = hold_full ? hold_data : '0;
  assign rx_next = MSB_FIRST ? {rx_shift[DATA_WIDTH-2:0], mosi_sr[2]}
                             : {mosi_sr[2], rx_shift[DATA_WIDTH-1:1]};

  // Handshake: tx_data is taken on a pclk edge where tx_valid && tx_ready;
  // tx_ready is high exactly while the holding register is empty.
  always_ff @(posedge pclk) begin
    if (areset) begin
      hold_data   <= '0;
      hold_full   <= 1'b0;
      tx_shift    <= '0;
      rx_shift    <= '0;
      cnt         <= '0;
      word_open   <= 1'b0;
      ur_pending  <= 1'b0;
      miso        <= 1'b0;
      miso_oe     <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      tx_underrun <= ur_now || (in_word && sample_edge && ur_pending);
      miso_oe     <= (state_d == ACTIVE);

      if (tx_valid && !hold_full) begin
        hold_data <= tx_data;
        hold_full <= 1'b1;
      end else if (word_start && hold_full) begin
        hold_full <= 1'b0;
      end

      if (leave) begin
        cnt        <= '0;
        word_open  <= 1'b0;
        ur_pending <= 1'b0;
        miso       <= 1'b0;
      end else begin
        if (word_start) begin
          tx_shift   <= tx_load;
          miso       <= MSB_FIRST ? tx_load[DATA_WIDTH-1] : tx_load[0];
          word_open  <= 1'b1;
          ur_pending <= ur_defer;
        end else if (in_word && shift_edge) begin
          tx_shift <= MSB_FIRST ? (tx_shift << 1) : (tx_shift >> 1);
          miso     <= MSB_FIRST ? tx_shift[DATA_WIDTH-2] : tx_shift[1];
        end

        if (in_word && sample_edge) begin
          rx_shift   <= rx_next;
          ur_pending <= 1'b0;
          if (cnt == LAST) begin
            cnt       <= '0;
            word_open <= 1'b0;
            rx_data   <= rx_next;
            rx_valid  <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
      end
    end
  end

  assign tx_ready  = ~hold_full;
  assign busy      = (state_q == ACTIVE) && ((cnt != '0) || (!CPHA && word_open));
  assign state_dbg = (state_q == ACTIVE);

endmodule

// File: tb/tb_spi_slave_agent.sv
// Directed bench for spi_slave_agent: three instances (mode 0 8-bit, mode 3 8-bit,
// mode 0 16-bit LSB first) driven by a bit-banged master with hand-computed results.
`timescale 1ns/1ps
module tb_spi_slave_agent;

  localparam int HALF = 4;

  logic        pclk = 1'b0;
  logic        areset;
  logic        mosi;
  logic        sclk_v[3];
  logic        cs_v[3];
  logic        tx_valid_v[3];
  logic        miso_v[3], oe_v[3], txr_v[3], rxv_v[3], ur_v[3], busy_v[3], st_v[3];
  logic [7:0]  tx_data0, tx_data1, rx_data0, rx_data1;
  logic [15:0] tx_data2, rx_data2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int edge_cyc = 0;
  int rxv_cyc0 = 0;
  int rxv_cnt[3] = '{0, 0, 0};
  int ur_cnt[3]  = '{0, 0, 0};
  logic [31:0] rx_log1[$];
  logic        loader_ok = 1'b0;
  logic [31:0] got, got2;
  int          dly;

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  spi_slave_agent u0 (
    .pclk(pclk), .areset(areset), .sclk(sclk_v[0]), .cs_n(cs_v[0]), .mosi(mosi),
    .miso(miso_v[0]), .miso_oe(oe_v[0]), .tx_data(tx_data0), .tx_valid(tx_valid_v[0]),
    .tx_ready(txr_v[0]), .rx_data(rx_data0), .rx_valid(rxv_v[0]),
    .tx_underrun(ur_v[0]), .busy(busy_v[0]), .state_dbg(st_v[0]));

  spi_slave_agent #(.CPOL(1'b1), .CPHA(1'b1)) u1 (
    .pclk(pclk), .areset(areset), .sclk(sclk_v[1]), .cs_n(cs_v[1]), .mosi(mosi),
    .miso(miso_v[1]), .miso_oe(oe_v[1]), .tx_data(tx_data1), .tx_valid(tx_valid_v[1]),
    .tx_ready(txr_v[1]), .rx_data(rx_data1), .rx_valid(rxv_v[1]),
    .tx_underrun(ur_v[1]), .busy(busy_v[1]), .state_dbg(st_v[1]));

  spi_slave_agent #(.DATA_WIDTH(16), .MSB_FIRST(1'b0)) u2 (
    .pclk(pclk), .areset(areset), .sclk(sclk_v[2]), .cs_n(cs_v[2]), .mosi(mosi),
    .miso(miso_v[2]), .miso_oe(oe_v[2]), .tx_data(tx_data2), .tx_valid(tx_valid_v[2]),
    .tx_ready(txr_v[2]), .rx_data(rx_data2), .rx_valid(rxv_v[2]),
    .tx_underrun(ur_v[2]), .busy(busy_v[2]), .state_dbg(st_v[2]));

  // pulse monitor, sampled away from the active edge
  always @(negedge pclk) begin
    for (int i = 0; i < 3; i++) begin
      if (rxv_v[i] === 1'b1) rxv_cnt[i] = rxv_cnt[i] + 1;
      if (ur_v[i] === 1'b1)  ur_cnt[i]  = ur_cnt[i] + 1;
    end
    if (rxv_v[0] === 1'b1) rxv_cyc0 = cyc;
    if (rxv_v[1] === 1'b1) rx_log1.push_back(32'(rx_data1));
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge pclk);
  endtask

  task automatic load_tx(input int idx, input logic [31:0] d);
    case (idx)
      0: tx_data0 = d[7:0];
      1: tx_data1 = d[7:0];
      default: tx_data2 = d[15:0];
    endcase
    tx_valid_v[idx] = 1'b1;
    @(negedge pclk);
    tx_valid_v[idx] = 1'b0;
  endtask

  task automatic spi_xfer(input int idx, input bit cpol, input bit cpha, input bit msb,
                          input int width, input int nbits, input logic [31:0] dout,
                          output logic [31:0] din);
    int b;
    din = '0;
    for (int i = 0; i < nbits; i++) begin
      b = msb ? (width - 1 - i) : i;
      if (!cpha) begin
        mosi = dout[b];
        wait_cyc(HALF);
        din[b] = miso_v[idx];
        sclk_v[idx] = ~cpol;
        edge_cyc = cyc;
        wait_cyc(HALF);
        sclk_v[idx] = cpol;
      end else begin
        sclk_v[idx] = ~cpol;
        mosi = dout[b];
        wait_cyc(HALF);
        din[b] = miso_v[idx];
        sclk_v[idx] = cpol;
        edge_cyc = cyc;
        wait_cyc(HALF);
      end
    end
  endtask

  initial begin
    areset = 1'b1;
    mosi = 1'b0;
    sclk_v = '{1'b0, 1'b1, 1'b0};
    cs_v = '{1'b1, 1'b1, 1'b1};
    tx_valid_v = '{1'b0, 1'b0, 1'b0};
    tx_data0 = '0; tx_data1 = '0; tx_data2 = '0;

    // reset
    wait_cyc(2);
    chk("rst_miso", 32'(miso_v[0]), 0);
    chk("rst_oe", 32'(oe_v[0]), 0);
    chk("rst_tx_ready", 32'(txr_v[0]), 1);
    chk("rst_rx_data", 32'(rx_data0), 0);
    chk("rst_rx_valid", 32'(rxv_v[0]), 0);
    chk("rst_underrun", 32'(ur_v[0]), 0);
    chk("rst_busy", 32'(busy_v[0]), 0);
    chk("rst_state", 32'(st_v[0]), 0);
    chk("rst_tx_ready_m3", 32'(txr_v[1]), 1);
    areset = 1'b0;
    wait_cyc(4);

    // mode 0, 8-bit: slave sends A5, master sends 3C
    load_tx(0, 32'hA5);
    chk("m0_hold_full", 32'(txr_v[0]), 0);
    cs_v[0] = 1'b0;
    wait_cyc(8);
    chk("m0_oe", 32'(oe_v[0]), 1);
    chk("m0_state", 32'(st_v[0]), 1);
    chk("m0_busy_loaded", 32'(busy_v[0]), 1);
    chk("m0_tx_ready_after_start", 32'(txr_v[0]), 1);
    chk("m0_first_bit", 32'(miso_v[0]), 1);
    spi_xfer(0, 1'b0, 1'b0, 1'b1, 8, 8, 32'h3C, got);
    wait_cyc(6);
    chk("m0_miso_word", got, 32'hA5);
    chk("m0_rx_data", 32'(rx_data0), 32'h3C);
    chk("m0_rx_valid_count", rxv_cnt[0], 1);
    dly = rxv_cyc0 - edge_cyc;
    chk("m0_rx_valid_latency_3to4", 32'((dly >= 3) && (dly <= 4)), 1);
    cs_v[0] = 1'b1;
    wait_cyc(8);
    chk("m0_oe_off", 32'(oe_v[0]), 0);
    chk("m0_miso_off", 32'(miso_v[0]), 0);
    chk("m0_busy_off", 32'(busy_v[0]), 0);
    chk("m0_no_underrun", ur_cnt[0], 0);

    // underrun: nothing loaded, master sends 5A
    cs_v[0] = 1'b0;
    wait_cyc(8);
    chk("ur_pulse", ur_cnt[0], 1);
    spi_xfer(0, 1'b0, 1'b0, 1'b1, 8, 8, 32'h5A, got);
    wait_cyc(6);
    chk("ur_miso_zero", got, 32'h00);
    chk("ur_rx_data", 32'(rx_data0), 32'h5A);
    chk("ur_rx_valid_count", rxv_cnt[0], 2);
    chk("ur_single_pulse", ur_cnt[0], 1);
    cs_v[0] = 1'b1;
    wait_cyc(8);

    // abort after 5 bits, holding register refilled mid-frame must survive
    load_tx(0, 32'hF0);
    cs_v[0] = 1'b0;
    wait_cyc(8);
    load_tx(0, 32'h0F);
    chk("ab_hold_full", 32'(txr_v[0]), 0);
    spi_xfer(0, 1'b0, 1'b0, 1'b1, 8, 5, 32'h55, got);
    wait_cyc(2);
    chk("ab_partial_miso", got, 32'hF0);
    chk("ab_busy_mid", 32'(busy_v[0]), 1);
    cs_v[0] = 1'b1;
    wait_cyc(8);
    chk("ab_no_rx_valid", rxv_cnt[0], 2);
    chk("ab_rx_data_kept", 32'(rx_data0), 32'h5A);
    chk("ab_hold_kept", 32'(txr_v[0]), 0);
    chk("ab_busy_off", 32'(busy_v[0]), 0);
    chk("ab_miso_off", 32'(miso_v[0]), 0);
    cs_v[0] = 1'b0;
    wait_cyc(8);
    spi_xfer(0, 1'b0, 1'b0, 1'b1, 8, 8, 32'hC3, got);
    wait_cyc(6);
    chk("ab_next_miso", got, 32'h0F);
    chk("ab_next_rx_data", 32'(rx_data0), 32'hC3);
    chk("ab_next_rx_count", rxv_cnt[0], 3);
    cs_v[0] = 1'b1;
    wait_cyc(8);

    // mode 3, back to back: 81 then 7E out, 12 then 34 in
    load_tx(1, 32'h81);
    cs_v[1] = 1'b0;
    wait_cyc(8);
    chk("m3_oe", 32'(oe_v[1]), 1);
    chk("m3_hold_until_edge", 32'(txr_v[1]), 0);
    chk("m3_busy_idle_word", 32'(busy_v[1]), 0);
    fork
      begin
        int n;
        n = 0;
        while (txr_v[1] !== 1'b1 && n < 400) begin
          @(negedge pclk);
          n++;
        end
        if (txr_v[1] === 1'b1) begin
          tx_data1 = 8'h7E;
          tx_valid_v[1] = 1'b1;
          @(negedge pclk);
          tx_valid_v[1] = 1'b0;
          loader_ok = 1'b1;
        end
      end
    join_none
    spi_xfer(1, 1'b1, 1'b1, 1'b1, 8, 8, 32'h12, got);
    spi_xfer(1, 1'b1, 1'b1, 1'b1, 8, 8, 32'h34, got2);
    wait_cyc(6);
    chk("m3_reload_seen", 32'(loader_ok), 1);
    chk("m3_miso_word1", got, 32'h81);
    chk("m3_miso_word2", got2, 32'h7E);
    chk("m3_rx_valid_count", rxv_cnt[1], 2);
    chk("m3_rx_word1", (rx_log1.size() > 0) ? rx_log1.pop_front() : 32'hx, 32'h12);
    chk("m3_rx_word2", (rx_log1.size() > 0) ? rx_log1.pop_front() : 32'hx, 32'h34);
    chk("m3_no_underrun", ur_cnt[1], 0);
    cs_v[1] = 1'b1;
    wait_cyc(8);

    // 16-bit LSB first: 1234 out, BEEF in
    load_tx(2, 32'h1234);
    cs_v[2] = 1'b0;
    wait_cyc(8);
    chk("lsb_first_bit", 32'(miso_v[2]), 0);
    spi_xfer(2, 1'b0, 1'b0, 1'b0, 16, 16, 32'hBEEF, got);
    wait_cyc(6);
    chk("lsb_miso_word", got, 32'h1234);
    chk("lsb_rx_data", 32'(rx_data2), 32'hBEEF);
    chk("lsb_rx_valid_count", rxv_cnt[2], 1);
    cs_v[2] = 1'b1;
    wait_cyc(8);

    // reset in the middle of a word
    cs_v[2] = 1'b0;
    wait_cyc(8);
    spi_xfer(2, 1'b0, 1'b0, 1'b0, 16, 5, 32'h001F, got);
    areset = 1'b1;
    @(negedge pclk);
    chk("mrst_rx_data", 32'(rx_data2), 0);
    chk("mrst_busy", 32'(busy_v[2]), 0);
    chk("mrst_oe", 32'(oe_v[2]), 0);
    chk("mrst_state", 32'(st_v[2]), 0);
    chk("mrst_tx_ready", 32'(txr_v[2]), 1);
    cs_v[2] = 1'b1;
    areset = 1'b0;
    wait_cyc(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
